// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the four-master system bus arbiter: master count,
// owner index width, master index constants, arbiter state encoding, the
// active-low signalling levels and a small one-hot helper.
// No ports (package).
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int OWNER_W     = 2;

    localparam logic [OWNER_W-1:0] BUS_OWNER_IF   = 2'd0;
    localparam logic [OWNER_W-1:0] BUS_OWNER_MEM  = 2'd1;
    localparam logic [OWNER_W-1:0] BUS_OWNER_AUX0 = 2'd2;
    localparam logic [OWNER_W-1:0] BUS_OWNER_AUX1 = 2'd3;

    typedef enum logic {
        BUS_ARB_IDLE  = 1'b0,
        BUS_ARB_OWNED = 1'b1
    } arb_state_t;

    localparam logic LEVEL_ASSERTED_N   = 1'b0;
    localparam logic LEVEL_DEASSERTED_N = 1'b1;

    // Active-high one-hot vector with only the bit for master idx set.
    function automatic logic [NUM_MASTERS-1:0] owner_onehot(input logic [OWNER_W-1:0] idx);
        return NUM_MASTERS'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches the active-high request
// vector starting at index 'start' and wrapping around; the first requester
// found wins.
// Ports:
//   req     in  4  active-high request vector
//   start   in  2  index searched first
//   winner  out 2  index of the winning requester (start when none)
//   valid   out 1  high when at least one request is present
// -----------------------------------------------------------------------------
module rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [OWNER_W-1:0]     start,
    output logic [OWNER_W-1:0]     winner,
    output logic                   valid
);

    // Walk the offsets from the farthest to the nearest so that the nearest
    // requester to 'start' is the last assignment and therefore wins. The
    // 2-bit index addition wraps naturally modulo four.
    always_comb begin
        logic [OWNER_W-1:0] idx;
        winner = start;
        valid  = 1'b0;
        idx    = start;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = start + OWNER_W'(i);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter sharing the system bus between four masters (IF, MEM,
// AUX0, AUX1). Requests and grants are active low; grants are registered and
// never more than one is low. Ownership is held until the owner releases its
// request; the next master is granted on the same edge with no idle cycle.
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to bound ownership. While other
// masters wait, a hold counter runs; when it reaches TIMEOUT_CYCLES-1 the
// grant is revoked, handed on, and timeout_err pulses for one cycle. Without
// the macro ownership is unbounded and timeout_err is tied low.
//
// Ports:
//   clk                      in  1  system clock
//   reset                    in  1  asynchronous reset, active low
//   m0_req_ .. m3_req_       in  1  bus request per master, active low
//   m0_grnt_ .. m3_grnt_     out 1  bus grant per master, active low
//   bus_owner                out 2  current/last owner index, steers bus mux
//   bus_busy                 out 1  high while a grant is asserted
//   timeout_err              out 1  one-cycle pulse on forced revocation
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               m0_req_,
    input  logic               m1_req_,
    input  logic               m2_req_,
    input  logic               m3_req_,
    output logic               m0_grnt_,
    output logic               m1_grnt_,
    output logic               m2_grnt_,
    output logic               m3_grnt_,
    output logic [OWNER_W-1:0] bus_owner,
    output logic               bus_busy,
    output logic               timeout_err
);

    arb_state_t               state;
    logic [NUM_MASTERS-1:0]   grnt_n;
    logic [NUM_MASTERS-1:0]   req;
    logic [NUM_MASTERS-1:0]   owner_mask;
    logic [NUM_MASTERS-1:0]   pick_req;
    logic [OWNER_W-1:0]       search_start;
    logic [OWNER_W-1:0]       pick_winner;
    logic                     pick_valid;
    logic                     owner_req;
    logic                     revoke;
    logic                     handover;

    assign req          = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_mask   = owner_onehot(bus_owner);
    assign owner_req    = |(req & owner_mask);
    assign search_start = bus_owner + OWNER_W'(1);

    // While owned, the owner is masked out of the search so that a revoked
    // owner cannot win its own grant back; on a normal release its request
    // is already inactive, so the mask changes nothing there.
    assign pick_req = (state == BUS_ARB_OWNED) ? (req & ~owner_mask) : req;

    rr_pick u_pick (
        .req    (pick_req),
        .start  (search_start),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] hold_cnt;
    logic        others_req;

    assign others_req = |(req & ~owner_mask);
    assign revoke     = (state == BUS_ARB_OWNED) && owner_req && others_req &&
                        (hold_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Hold counter counts contended ownership cycles. It restarts whenever the
    // grant moves (new grant from idle, release, revocation) or nobody else is
    // waiting. Revocation fires at the limit, so the counter never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= revoke;
            if ((state != BUS_ARB_OWNED) || !owner_req || !others_req || revoke) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign revoke             = 1'b0;
    assign timeout_err        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    assign handover = (state == BUS_ARB_OWNED) && (!owner_req || revoke);

    // Arbiter FSM with registered grants, owner and busy flag. From IDLE the
    // first winner is granted; while OWNED the grant moves only on release
    // (or revocation), straight to the next winner, falling back to IDLE
    // with bus_owner left at the last owner when no one else is requesting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= BUS_ARB_IDLE;
            grnt_n    <= {NUM_MASTERS{LEVEL_DEASSERTED_N}};
            bus_owner <= BUS_OWNER_IF;
            bus_busy  <= 1'b0;
        end else begin
            case (state)
                BUS_ARB_IDLE: begin
                    if (pick_valid) begin
                        state     <= BUS_ARB_OWNED;
                        grnt_n    <= ~owner_onehot(pick_winner);
                        bus_owner <= pick_winner;
                        bus_busy  <= 1'b1;
                    end
                end
                BUS_ARB_OWNED: begin
                    if (handover) begin
                        if (pick_valid) begin
                            grnt_n    <= ~owner_onehot(pick_winner);
                            bus_owner <= pick_winner;
                        end else begin
                            state    <= BUS_ARB_IDLE;
                            grnt_n   <= {NUM_MASTERS{LEVEL_DEASSERTED_N}};
                            bus_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= BUS_ARB_IDLE;
                    grnt_n   <= {NUM_MASTERS{LEVEL_DEASSERTED_N}};
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

    assign m0_grnt_ = grnt_n[0];
    assign m1_grnt_ = grnt_n[1];
    assign m2_grnt_ = grnt_n[2];
    assign m3_grnt_ = grnt_n[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter. The driver applies requests on the
// falling edge and pushes the expected post-edge outputs, computed by a
// behavioural round-robin model, into a scoreboard queue; a monitor pops and
// compares just after every rising edge. Directed scenarios are followed by
// randomized master traffic and an asynchronous reset during ownership.
// Honours BUS_ARB_TIMEOUT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TO = 8;

    typedef struct {
        logic [3:0] grnt_n;
        logic [1:0] owner;
        logic       busy;
        logic       terr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_n;
    logic [3:0] grnt_n;
    logic [1:0] bus_owner;
    logic       bus_busy;
    logic       timeout_err;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   m_owner = 0;
    bit   m_busy  = 1'b0;
    int   m_hold  = 0;

    bit [3:0] want     = 4'b0000;
    int       hold_len[4];

    bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req_     (req_n[0]),
        .m1_req_     (req_n[1]),
        .m2_req_     (req_n[2]),
        .m3_req_     (req_n[3]),
        .m0_grnt_    (grnt_n[0]),
        .m1_grnt_    (grnt_n[1]),
        .m2_grnt_    (grnt_n[2]),
        .m3_grnt_    (grnt_n[3]),
        .bus_owner   (bus_owner),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // First requester found searching from the master after 'from', wrapping.
    function automatic int search(input bit [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
        end
    endtask

    // Advance the reference model by one clock edge with active-high requests
    // r and queue the outputs the arbiter should then present.
    task automatic modelStep(input bit [3:0] r);
        exp_t e;
        bit   terr;
        int   w;
        terr = 1'b0;
        if (!m_busy) begin
            w = search(r, m_owner);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_hold  = 0;
            end
        end else if (!r[m_owner]) begin
            w      = search(r, m_owner);
            m_hold = 0;
            if (w >= 0) m_owner = w;
            else        m_busy  = 1'b0;
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            bit [3:0] others;
            others          = r;
            others[m_owner] = 1'b0;
            if (others != 4'b0000 && m_hold == TO - 1) begin
                m_owner = search(others, m_owner);
                terr    = 1'b1;
                m_hold  = 0;
            end else if (others != 4'b0000) begin
                m_hold++;
            end else begin
                m_hold = 0;
            end
`endif
        end
        e.grnt_n = 4'hF;
        if (m_busy) e.grnt_n[m_owner] = 1'b0;
        e.owner = 2'(m_owner);
        e.busy  = m_busy;
        e.terr  = terr;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input bit [3:0] r);
        @(negedge clk);
        req_n = ~r;
        modelStep(r);
    endtask

    // Randomized masters: idle masters occasionally start requesting and keep
    // requesting until served; the owner holds for its chosen length, then
    // drops its request (and may re-request on the very next cycle).
    task automatic runMasters(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_busy && m_owner == i && want[i]) begin
                    if (hold_len[i] == 0) want[i] = 1'b0;
                    else hold_len[i]--;
                end else if (!want[i] && $urandom_range(0, 3) == 0) begin
                    want[i]     = 1'b1;
                    hold_len[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 20))
                                                              : int'($urandom_range(1, 5));
                end
            end
            applyStimulus(want);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " grants"}, int'(grnt_n), 15);
        checkOutput({tag, " bus_owner"}, int'(bus_owner), 0);
        checkOutput({tag, " bus_busy"}, int'(bus_busy), 0);
        checkOutput({tag, " timeout_err"}, int'(timeout_err), 0);
    endtask

    // Scoreboard monitor: just after each rising edge, compare the DUT outputs
    // with the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("grants", int'(grnt_n), int'(e.grnt_n));
            checkOutput("bus_owner", int'(bus_owner), int'(e.owner));
            checkOutput("bus_busy", int'(bus_busy), int'(e.busy));
            checkOutput("timeout_err", int'(timeout_err), int'(e.terr));
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed scenarios, random traffic, async reset.
    initial begin
        reset = 1'b0;
        req_n = 4'hF;
        for (int i = 0; i < 4; i++) hold_len[i] = 0;
        repeat (2) @(posedge clk);
        #2;
        checkResetOutputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Lone m0 request, held two cycles then released.
        applyStimulus(4'b0001);
        applyStimulus(4'b0001);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);

        // All four request, every owner holds for three cycles.
        want = 4'hF;
        for (int i = 0; i < 4; i++) hold_len[i] = 2;
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_busy && m_owner == i && want[i]) begin
                    if (hold_len[i] == 0) want[i] = 1'b0;
                    else hold_len[i]--;
                end
            end
            applyStimulus(want);
        end
        applyStimulus(4'b0000);

        // m2 owns, releases while m0 and m3 wait: m3 then m0.
        applyStimulus(4'b0100);
        applyStimulus(4'b1101);
        applyStimulus(4'b1001);
        applyStimulus(4'b0001);
        applyStimulus(4'b0000);

        // Release with nobody waiting, then a new m1 request two cycles later.
        applyStimulus(4'b0010);
        applyStimulus(4'b0010);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);
        applyStimulus(4'b0010);
        applyStimulus(4'b0000);

        // m0 holds while m1 waits continuously (revocation when enabled).
        for (int c = 0; c < 12; c++) applyStimulus(4'b0011);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);

        // Randomized traffic.
        want = 4'b0000;
        runMasters(3000);
        want = 4'b0000;
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);

        // m3 owns, then reset is asserted between clock edges.
        applyStimulus(4'b1000);
        applyStimulus(4'b1000);
        @(posedge clk);
        #3;
        reset = 1'b0;
        req_n = 4'hF;
        #1;
        checkResetOutputs("async reset");
        m_owner = 0;
        m_busy  = 1'b0;
        m_hold  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(4'b0100);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);

        @(posedge clk);
        #2;
        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
